vlc_4b6b_tx_serializer: RTL

//   Transmit-side VLC line stage. Accepts payload bytes over a valid/ready

---
 rtl/vlc_pkg.sv | 27 ++
 rtl/fourBit2SixBit.sv | 14 +
 rtl/vlc_4b6b_tx_serializer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/vlc_pkg.sv
// Shared definitions for the VLC 4B6B line stage.
// Holds the transmit FSM state type, the default start-of-frame delimiter
// and the 4B6B code table (also used by the receive-side decoder).
package vlc_pkg;

    // Transmit FSM states
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PREAMBLE = 2'd1,
        S_SFD      = 2'd2,
        S_DATA     = 2'd3
    } state_t;

    // Start delimiter; deliberately not a legal 4B6B codeword so the
    // receiver can lock onto it unambiguously.
    localparam logic [5:0] SFD_DEFAULT = 6'b000111;

    // 4B6B code table indexed by nibble value. Every codeword has three
    // ones and three zeros, keeping the LED DC-balanced.
    localparam logic [5:0] ENC_4B6B [16] = '{
        6'b001110, 6'b001101, 6'b010011, 6'b010110,
        6'b010101, 6'b100011, 6'b100110, 6'b100101,
        6'b011001, 6'b011010, 6'b011100, 6'b110001,
        6'b110010, 6'b101001, 6'b101010, 6'b101100
    };

endpackage

// File: rtl/fourBit2SixBit.sv
// 4B6B nibble encoder (purely combinational table lookup).
// Ports:
//   i_nibble  in   4  nibble to encode
//   o_symbol  out  6  6-bit line symbol, sent MSB first
module fourBit2SixBit
    import vlc_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [5:0] o_symbol
);

    assign o_symbol = ENC_4B6B[i_nibble];

endmodule

// File: rtl/vlc_4b6b_tx_serializer.sv
// Transmit-side VLC line stage. Takes payload bytes over a valid/ready
// handshake, 4B6B-encodes each byte as high nibble then low nibble, and
// sends every frame as preamble + SFD + data symbols, one bit per
// CLK_DIV clocks on the LED drive line.
// Ports:
//   clk          in   1  system clock
//   rst_n        in   1  asynchronous active-low reset
//   tx_data      in   8  payload byte
//   tx_valid     in   1  tx_data / tx_last valid
//   tx_last      in   1  byte is the last one of its frame
//   tx_ready     out  1  holding register empty
//   tx_out       out  1  serial line bit, idle level 0
//   tx_busy      out  1  frame in progress
//   tx_underrun  out  1  one-clock pulse when a frame is aborted for lack of data
// Handshake: a byte is taken on the rising clk edge where tx_valid and
// tx_ready are both high. tx_ready depends only on registered state, so
// a byte is never passed through combinationally in the same cycle.
module vlc_4b6b_tx_serializer
    import vlc_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 16,
    parameter int unsigned PREAMBLE_LEN = 8,
    parameter logic [5:0]  SFD          = SFD_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       tx_out,
    output logic       tx_busy,
    output logic       tx_underrun
);

    localparam logic [15:0] LP_CNT_LAST = 16'(CLK_DIV - 1);
    localparam logic [7:0]  LP_PRE_LAST = 8'(PREAMBLE_LEN - 1);

    state_t      r_state;
    state_t      w_next_state;

    logic [15:0] r_cnt;        // clock within the current line bit
    logic [7:0]  r_idx;        // bit within preamble, or within SFD/data symbol
    logic        r_low;        // data symbol in flight is the low nibble
    logic [4:0]  r_shift;      // symbol bits still to be sent after the current one
    logic        r_tx_out;
    logic        r_underrun;

    logic [7:0]  r_hold_data;
    logic        r_hold_last;
    logic        r_hold_full;
    logic [7:0]  r_cur_data;
    logic        r_cur_last;

    logic        w_bit_end;
    logic        w_sym_end;
    logic        w_pre_end;
    logic        w_start;
    logic        w_take_hold;
    logic        w_load_low;
    logic        w_frame_done;
    logic        w_underrun;
    logic [7:0]  w_cur_data_next;
    logic [3:0]  w_nibble;
    logic [5:0]  w_symbol;

    // ---------------- bit timing ----------------
    assign w_bit_end = (r_state != S_IDLE) && (r_cnt == LP_CNT_LAST);
    assign w_sym_end = w_bit_end && (r_idx == 8'd5);
    assign w_pre_end = (r_state == S_PREAMBLE) && w_bit_end && (r_idx == LP_PRE_LAST);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:     if (w_start)                     w_next_state = S_PREAMBLE;
            S_PREAMBLE: if (w_pre_end)                   w_next_state = S_SFD;
            S_SFD:      if (w_sym_end)                   w_next_state = S_DATA;
            S_DATA:     if (w_frame_done || w_underrun)  w_next_state = S_IDLE;
            default:                                     w_next_state = S_IDLE;
        endcase
    end

    // ---------------- FSM: control outputs ----------------
    always_comb begin
        w_start      = 1'b0;
        w_take_hold  = 1'b0;
        w_load_low   = 1'b0;
        w_frame_done = 1'b0;
        w_underrun   = 1'b0;
        case (r_state)
            S_IDLE: w_start     = r_hold_full;
            S_SFD:  w_take_hold = w_sym_end;
            S_DATA: begin
                if (w_sym_end) begin
                    if (!r_low) begin
                        w_load_low = 1'b1;
                    end else if (r_cur_last) begin
                        w_frame_done = 1'b1;
                    end else if (r_hold_full) begin
                        w_take_hold = 1'b1;
                    end else begin
                        w_underrun = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // ---------------- encoder and nibble mux ----------------
    // The high symbol is loaded on the same edge that moves hold into cur,
    // so the mux looks at the value cur is about to take.
    assign w_cur_data_next = w_take_hold ? r_hold_data : r_cur_data;
    assign w_nibble        = w_load_low ? r_cur_data[3:0] : w_cur_data_next[7:4];

    fourBit2SixBit u_enc (
        .i_nibble (w_nibble),
        .o_symbol (w_symbol)
    );

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_low       <= 1'b0;
            r_shift     <= '0;
            r_tx_out    <= 1'b0;
            r_underrun  <= 1'b0;
            r_hold_data <= '0;
            r_hold_last <= 1'b0;
            r_hold_full <= 1'b0;
            r_cur_data  <= '0;
            r_cur_last  <= 1'b0;
        end else begin
            r_underrun <= w_underrun;
            r_cnt      <= ((r_state == S_IDLE) || w_bit_end) ? 16'd0 : r_cnt + 16'd1;

            // Byte registers. An accept and a move never coincide because
            // tx_ready is low whenever hold is full.
            r_cur_data <= w_cur_data_next;
            r_cur_last <= w_take_hold ? r_hold_last : r_cur_last;
            if (w_take_hold) begin
                r_hold_full <= 1'b0;
            end else if (tx_valid && !r_hold_full) begin
                r_hold_data <= tx_data;
                r_hold_last <= tx_last;
                r_hold_full <= 1'b1;
            end

            // Line output: changes only on PREAMBLE entry or after a bit end
            if (w_start) begin
                r_tx_out <= 1'b1;
                r_idx    <= '0;
            end else if (w_bit_end) begin
                case (r_state)
                    S_PREAMBLE: begin
                        if (w_pre_end) begin
                            r_idx    <= '0;
                            r_tx_out <= SFD[5];
                            r_shift  <= SFD[4:0];
                        end else begin
                            // preamble starts at 1 and alternates
                            r_idx    <= r_idx + 8'd1;
                            r_tx_out <= ~r_tx_out;
                        end
                    end
                    S_SFD, S_DATA: begin
                        if (w_take_hold || w_load_low) begin
                            r_idx    <= '0;
                            r_low    <= w_load_low;
                            r_tx_out <= w_symbol[5];
                            r_shift  <= w_symbol[4:0];
                        end else if (w_frame_done || w_underrun) begin
                            r_idx    <= '0;
                            r_low    <= 1'b0;
                            r_tx_out <= 1'b0;
                        end else begin
                            r_idx    <= r_idx + 8'd1;
                            r_tx_out <= r_shift[4];
                            r_shift  <= {r_shift[3:0], 1'b0};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign tx_ready    = ~r_hold_full;
    assign tx_out      = r_tx_out;
    assign tx_busy     = (r_state != S_IDLE);
    assign tx_underrun = r_underrun;

endmodule
